cpu86_exec_vld_emitter: RTL

//  Producer side of the exec-unit validation trace (vld_* stream) consumed by the golden-model checker.

---
 rtl/cpu86_exec_vld_emitter_if.sv | 57 +++++
 rtl/cpu86_exec_vld_emitter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cpu86_exec_vld_emitter_if.sv
// ---------------------------------------------------------------------------
// cpu86_exec_vld_emitter_if
// Bundle of the signals between the exec unit, the validation emitter and the
// trace consumer.
//   issue_*  : in-order issue descriptors (valid/ready handshake)
//   wb_*     : architectural register writeback strobe
//   done_*   : in-order retire strobe for the oldest issued instruction
//   vld_*    : one-cycle trace pulse with descriptor and post-retire registers
//   err_*    : sticky error flags
// Modport master is the exec-unit / bench side; modport slave is the emitter.
// ---------------------------------------------------------------------------
interface cpu86_exec_vld_emitter_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_op;
    logic [3:0]  issue_code;
    logic [15:0] issue_cs;
    logic [15:0] issue_ip;
    logic        wb_valid;
    logic [3:0]  wb_sel;
    logic [15:0] wb_data;
    logic        done_valid;
    logic        vld_valid;
    logic [4:0]  vld_op;
    logic [3:0]  vld_code;
    logic [15:0] vld_cs;
    logic [15:0] vld_ip;
    logic [15:0] vld_ax;
    logic [15:0] vld_bx;
    logic [15:0] vld_cx;
    logic [15:0] vld_dx;
    logic [15:0] vld_bp;
    logic [15:0] vld_sp;
    logic [15:0] vld_si;
    logic [15:0] vld_di;
    logic [15:0] vld_fl;
    logic        err_overflow;
    logic        err_underrun;

    modport master (
        output issue_valid, issue_op, issue_code, issue_cs, issue_ip,
        output wb_valid, wb_sel, wb_data, done_valid,
        input  issue_ready,
        input  vld_valid, vld_op, vld_code, vld_cs, vld_ip,
        input  vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl,
        input  err_overflow, err_underrun
    );

    modport slave (
        input  issue_valid, issue_op, issue_code, issue_cs, issue_ip,
        input  wb_valid, wb_sel, wb_data, done_valid,
        output issue_ready,
        output vld_valid, vld_op, vld_code, vld_cs, vld_ip,
        output vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl,
        output err_overflow, err_underrun
    );
endinterface

// File: rtl/cpu86_exec_vld_emitter.sv
// ---------------------------------------------------------------------------
// cpu86_exec_vld_emitter
// Producer of the exec-unit validation trace. Queues issue descriptors in a
// small FIFO, shadows the architectural registers from writeback, and on each
// in-order retire emits one vld_valid pulse with the retired descriptor and
// the register state after retire.
// Ports:
//   clk     : clock
//   resetn  : synchronous active-low reset
//   bus     : cpu86_exec_vld_emitter_if.slave (issue/wb/done in, vld/err out)
// ---------------------------------------------------------------------------
module cpu86_exec_vld_emitter #(
    parameter int          DEPTH  = 4,
    parameter logic [15:0] SP_RST = 16'h0000,
    parameter logic [15:0] FL_RST = 16'h0002
) (
    input  logic                          clk,
    input  logic                          resetn,
    cpu86_exec_vld_emitter_if.slave       bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int NREG = 9;   // AX BX CX DX BP SP SI DI FL
    localparam int SP_IDX = 5;
    localparam int FL_IDX = 8;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  code;
        logic [15:0] cs;
        logic [15:0] ip;
    } desc_t;

    desc_t          r_fifo [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_shadow [NREG];
    logic [15:0]    r_vld_reg [NREG];
    desc_t          r_vld_desc;
    logic           r_vld_valid;
    logic           r_err_overflow;
    logic           r_err_underrun;
    logic [5:0]     r_stall_cnt;

    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_stall;
    logic [15:0]    w_shadow_nxt [NREG];
    desc_t          w_issue_desc;

    // Ready depends on the registered count only: a pop in the same cycle
    // does not free a slot for a push.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = bus.issue_valid && !w_full;
    assign w_pop   = bus.done_valid && (r_count != '0);
    assign w_stall = bus.issue_valid && w_full;

    assign w_issue_desc = '{op: bus.issue_op, code: bus.issue_code,
                            cs: bus.issue_cs, ip: bus.issue_ip};

    // Shadow state after this cycle's writeback; the retire snapshot uses it
    // so a writeback landing on the retire cycle shows up in the trace.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (bus.wb_valid && (bus.wb_sel == 4'(i)))
                w_shadow_nxt[i] = bus.wb_data;
        end
    end

    // Descriptor storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_issue_desc;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_vld_valid    <= 1'b0;
            r_vld_desc     <= '0;
            r_err_overflow <= 1'b0;
            r_err_underrun <= 1'b0;
            r_stall_cnt    <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_shadow[i]  <= 16'h0000;
                r_vld_reg[i] <= 16'h0000;
            end
            r_shadow[SP_IDX] <= SP_RST;
            r_shadow[FL_IDX] <= FL_RST;
        end else begin
            for (int i = 0; i < NREG; i++)
                r_shadow[i] <= w_shadow_nxt[i];

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            r_vld_valid <= w_pop;
            if (w_pop) begin
                r_vld_desc <= r_fifo[r_rd_ptr];
                for (int i = 0; i < NREG; i++)
                    r_vld_reg[i] <= w_shadow_nxt[i];
            end

            if (bus.done_valid && (r_count == '0))
                r_err_underrun <= 1'b1;

            // Stall watchdog: a blocked issue is normal back-pressure; only a
            // run of 64 consecutive blocked cycles flags an overflow.
            if (w_stall) begin
                if (r_stall_cnt == 6'd63)
                    r_err_overflow <= 1'b1;
                else
                    r_stall_cnt <= r_stall_cnt + 6'd1;
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign bus.issue_ready  = !w_full;
    assign bus.vld_valid    = r_vld_valid;
    assign bus.vld_op       = r_vld_desc.op;
    assign bus.vld_code     = r_vld_desc.code;
    assign bus.vld_cs       = r_vld_desc.cs;
    assign bus.vld_ip       = r_vld_desc.ip;
    assign bus.vld_ax       = r_vld_reg[0];
    assign bus.vld_bx       = r_vld_reg[1];
    assign bus.vld_cx       = r_vld_reg[2];
    assign bus.vld_dx       = r_vld_reg[3];
    assign bus.vld_bp       = r_vld_reg[4];
    assign bus.vld_sp       = r_vld_reg[5];
    assign bus.vld_si       = r_vld_reg[6];
    assign bus.vld_di       = r_vld_reg[7];
    assign bus.vld_fl       = r_vld_reg[8];
    assign bus.err_overflow = r_err_overflow;
    assign bus.err_underrun = r_err_underrun;

endmodule
